// File: rtl/mem_port_arbiter_if.sv
// Shared memory-port bus between the arbiter (master) and the unified
// instruction/data memory (slave): registered req/gnt/rvalid handshake.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single shared memory port between IF fetches and MEM
// loads/stores, one outstanding transaction at a time, MEM first.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_kill_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_valid_o,
  output logic              stall_if_o,
  output logic              stall_mem_o,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
  typedef enum logic {OWN_IF, OWN_MEM} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              killed_q, killed_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              if_valid_q, if_valid_d;
  logic              mem_valid_q, mem_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              kill_hit;

  assign kill_hit = if_kill_i && (owner_q == OWN_IF);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    killed_d    = killed_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_valid_d  = 1'b0;
    mem_valid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    unique case (state_q)
      IDLE: begin
        killed_d = 1'b0;
        if (mem_read_i || mem_write_i) begin
          owner_d     = OWN_MEM;
          bus_we_d    = mem_write_i;
          bus_addr_d  = mem_addr_i;
          bus_wdata_d = mem_wdata_i;
          bus_req_d   = 1'b1;
          state_d     = REQ;
        end else if (if_req_i) begin
          owner_d     = OWN_IF;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr_i;
          bus_wdata_d = '0;
          bus_req_d   = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (kill_hit) killed_d = 1'b1;
        if (bus.bus_gnt) begin
          bus_req_d = 1'b0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (kill_hit) killed_d = 1'b1;
        if (bus.bus_rvalid) begin
          // A redirected fetch is dropped silently; its data never reaches IF.
          if ((owner_q == OWN_IF) && (killed_q || if_kill_i)) begin
            killed_d = 1'b0;
            state_d  = IDLE;
          end else if (owner_q == OWN_MEM) begin
            mem_valid_d = 1'b1;
            mem_rdata_d = bus_we_q ? '0 : bus.bus_rdata;
            state_d     = DONE;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.bus_rdata;
            state_d    = DONE;
          end
        end
      end
      DONE: begin
        killed_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      killed_q    <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      killed_q    <= killed_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_valid_q  <= if_valid_d;
      mem_valid_q <= mem_valid_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // A late redirect in the completion cycle still suppresses the fetch pulse.
  assign if_valid_o    = if_valid_q && !if_kill_i;
  assign mem_valid_o   = mem_valid_q;
  assign if_rdata_o    = if_rdata_q;
  assign mem_rdata_o   = mem_rdata_q;
  assign stall_if_o    = if_req_i && !if_valid_o;
  assign stall_mem_o   = (mem_read_i || mem_write_i) && !mem_valid_o;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Schedules the single shared memory port of the RV32I pipeline between instruction fetch (IF) and the data-memory stage (MEM). It accepts one fetch request and one load/store request per cycle, grants the bus to one owner at a time, and runs a registered req/gnt/rvalid handshake with one outstanding transaction. It produces per-stage completion pulses and stall signals that the pipeline register enables consume. It sits between the IF/MEM stages, which are driven by the decoder's mem_read/mem_write, and the unified instruction/data memory.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  IF wants an instruction word at if_addr
- if_addr  in  ADDR_W  fetch address; stable while if_req && stall_if
- if_kill  in  1  branch/jump redirect; discard the in-flight fetch
- if_rdata  out  DATA_W  fetched word; valid with if_valid
- if_valid  out  1  one-cycle fetch completion pulse
- mem_read, mem_write  in  1 each  MEM-stage load/store request (never both)
- mem_addr, mem_wdata  in  ADDR_W, DATA_W  load/store address and store data
- mem_rdata  out  DATA_W  load data; valid with mem_valid, 0 for stores
- mem_valid  out  1  one-cycle load/store completion pulse
- stall_if, stall_mem  out  1 each  hold the respective stage
- bus_req, bus_we  out  1 each  memory request and write enable (registered)
- bus_addr, bus_wdata  out  ADDR_W, DATA_W  request payload (registered)
- bus_gnt  in  1  memory accepts the request this cycle
- bus_rvalid  in  1  response/write-ack; at least one cycle after bus_gnt
- bus_rdata  in  DATA_W  read data with bus_rvalid

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Owner register: IF or MEM. Kill flag: killed.
- IDLE: if mem_read|mem_write, capture the MEM payload and set owner=MEM. Otherwise, if if_req, capture the IF payload with bus_we=0 and set owner=IF. Either case moves to REQ. MEM has fixed priority over IF on simultaneous requests.
- REQ: bus_req=1 with the payload held constant. On bus_gnt, move to WAIT. A request is never retracted.
- WAIT: bus_req=0. On bus_rvalid, register bus_rdata into the owner's rdata and move to DONE. If owner=IF and killed (or if_kill this cycle), move to IDLE instead with no pulse.
- DONE: pulse the owner's valid for one cycle. In that cycle the pulse is suppressed if owner=IF and if_kill is high. Move to IDLE. No new request is accepted in DONE, because the pipeline advances on this edge.
- killed is set by if_kill while owner=IF in REQ or WAIT. It is cleared on entry to IDLE. if_kill has no effect while owner=MEM or in IDLE.
- stall_mem = (mem_read|mem_write) && !mem_valid.
- stall_if = if_req && !if_valid.
- Stores: bus_we=1, bus_wdata=mem_wdata, and bus_rvalid serves as the ack. mem_rdata is 0.
- bus_rvalid in IDLE, REQ or DONE is ignored. bus_gnt outside REQ is ignored.
- if_rdata and mem_rdata hold their last value between pulses.

## Timing
- Reset (async, any state): state=IDLE, owner=IF, killed=0. All outputs are 0: bus_req, bus_we, bus_addr, bus_wdata, if_valid, mem_valid, if_rdata, mem_rdata. stall_* follow their equations.
- A response arriving after a mid-transaction reset is dropped.
- Request sampled in IDLE at cycle N → bus_req=1 at N+1.
- bus_gnt at cycle G → WAIT from G+1.
- bus_rvalid at cycle R → valid pulse and data at R+1 (DONE) → IDLE at R+2.
- Minimum turnaround with gnt the same cycle as bus_req and rvalid one cycle later: request N, bus_req N+1, rvalid N+2, valid N+3, next bus_req N+5.
- With an always-ready memory, the port serves one access every 4 cycles.
- A pending IF request waits while MEM owns the bus. The lower-priority requester keeps stalling until it is served.

## Test plan
- Fetch only, memory gnt same cycle and rvalid +1: if_req=1, if_addr=0x100, bus_rdata=0x00500093 → bus_req at N+1 with addr 0x100 and we=0; if_valid with if_rdata=0x00500093 at N+3; stall_if high N..N+2.
- Simultaneous if_req (0x104) and mem_read (0x2000) → bus_addr=0x2000 first, mem_valid pulse, then fetch 0x104 issued; stall_if stays high throughout.
- Store mem_write=1, addr 0x2004, wdata 0xDEADBEEF, gnt delayed 3 cycles → bus_req/bus_we and payload held stable through the delay; mem_valid once with mem_rdata=0.
- if_kill asserted during WAIT of fetch 0x108 → no if_valid; FSM returns to IDLE the cycle after rvalid; the new if_addr=0x200 is issued next.
- rst_n pulled low during WAIT → all outputs 0 immediately; a late bus_rvalid is ignored; no valid pulse appears.
- Spurious bus_rvalid while in IDLE and bus_gnt while in WAIT → no state change and no pulses.
